// File: rtl/timer_bank_pkg.sv
// Shared encodings and CTRL/select layout helpers for the timer bank.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_HALT     = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } chan_state_t;

    function automatic int ctrl_mode_lsb(input int ch);
        return 2 * ch;
    endfunction

    function automatic int ctrl_en_bit(input int nch, input int ch);
        return 2 * nch + ch;
    endfunction

    function automatic int ctrl_irq_en_bit(input int nch, input int ch);
        return 3 * nch + ch;
    endfunction

    function automatic int sel_ctrl(input int nch);
        return nch;
    endfunction

    function automatic int sel_pend(input int nch);
        return nch + 1;
    endfunction

endpackage

// File: rtl/timer_chan.sv
// One timer channel: reload/count registers, IDLE/RUN/DONE state and terminal output.
module timer_chan
    import timer_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             edge_i,
    input  mode_t            mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic             ch_out_o,
    output logic             term_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    chan_state_t      state_q, state_d;
    logic             ch_out_q, ch_out_d;
    logic             pulse_q, pulse_d;
    logic             term_s;

    // Channel state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q  <= '0;
            reload_q <= '0;
            state_q  <= IDLE;
            ch_out_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            state_q  <= state_d;
            ch_out_q <= ch_out_d;
            pulse_q  <= pulse_d;
        end
    end

    // Next state: a reload write overrides any count edge in the same cycle
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        state_d  = state_q;
        pulse_d  = 1'b0;
        term_s   = 1'b0;
        // a periodic terminal pulse lasts exactly one clock
        if (pulse_q) begin
            ch_out_d = 1'b0;
        end else begin
            ch_out_d = ch_out_q;
        end
        if (load_i) begin
            reload_d = load_val_i;
            count_d  = load_val_i;
            if (load_val_i != {WIDTH{1'b0}}) begin
                state_d = RUN;
                if (mode_i == MODE_SQUARE) begin
                    ch_out_d = ch_out_q;
                end else begin
                    ch_out_d = 1'b0;
                end
            end else begin
                state_d = IDLE;
            end
        end else if (state_q == RUN && edge_i && mode_i != MODE_HALT) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
                term_s = 1'b1;
                case (mode_i)
                    MODE_ONESHOT: begin
                        count_d  = '0;
                        ch_out_d = 1'b1;
                        state_d  = DONE;
                    end
                    MODE_PERIODIC: begin
                        count_d  = reload_q;
                        ch_out_d = 1'b1;
                        pulse_d  = 1'b1;
                    end
                    MODE_SQUARE: begin
                        count_d  = reload_q;
                        ch_out_d = ~ch_out_q;
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    assign count_o  = count_q;
    assign ch_out_o = ch_out_q;
    assign term_o   = term_s;

endmodule

// File: rtl/timer_bank_n.sv
// N-channel down-counter/timer bank with CTRL, sticky PEND, masked irq and readback mux.
module timer_bank_n
    import timer_bank_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int WIDTH = 32,
    parameter int SEL_W = $clog2(NCH + 2)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NCH-1:0]   tick,
    input  logic             counter_we,
    input  logic [SEL_W-1:0] counter_ch,
    input  logic [WIDTH-1:0] counter_val,
    output logic [WIDTH-1:0] counter_out,
    output logic [NCH-1:0]   ch_out,
    output logic             irq
);

    localparam int               CTRL_W   = 4 * NCH;
    localparam int               NSEL     = 1 << SEL_W;
    localparam logic [SEL_W-1:0] SEL_CTRL = SEL_W'(sel_ctrl(NCH));
    localparam logic [SEL_W-1:0] SEL_PEND = SEL_W'(sel_pend(NCH));

    logic [NCH-1:0]    tick_q, tick_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [NCH-1:0]    pend_q, pend_d;
    logic              irq_q, irq_d;
    logic [NCH-1:0]    tick_edge_s, en_s, irq_en_s, term_s, load_s, w1c_s;
    logic [WIDTH-1:0]  count_s [NSEL];

    assign tick_edge_s = tick & ~tick_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        localparam int MB = ctrl_mode_lsb(g);
        assign en_s[g]     = ctrl_q[ctrl_en_bit(NCH, g)];
        assign irq_en_s[g] = ctrl_q[ctrl_irq_en_bit(NCH, g)];
        assign load_s[g]   = counter_we && (counter_ch == SEL_W'(g));

        timer_chan #(.WIDTH(WIDTH)) u_chan (
            .clk        (clk),
            .rstn       (rstn),
            .load_i     (load_s[g]),
            .load_val_i (counter_val),
            .edge_i     (tick_edge_s[g] & en_s[g]),
            .mode_i     (mode_t'(ctrl_q[MB+1:MB])),
            .count_o    (count_s[g]),
            .ch_out_o   (ch_out[g]),
            .term_o     (term_s[g])
        );
    end

    for (genvar g = NCH; g < NSEL; g++) begin : g_nosel
        assign count_s[g] = '0;
    end

    // Bank-level registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_q <= '0;
            ctrl_q <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            tick_q <= tick_d;
            ctrl_q <= ctrl_d;
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    // CTRL write, PEND set/W1C (set wins), irq from registered PEND and mask
    always_comb begin
        tick_d = tick;
        if (counter_we && counter_ch == SEL_CTRL) begin
            ctrl_d = counter_val[CTRL_W-1:0];
        end else begin
            ctrl_d = ctrl_q;
        end
        if (counter_we && counter_ch == SEL_PEND) begin
            w1c_s = counter_val[NCH-1:0];
        end else begin
            w1c_s = '0;
        end
        pend_d = (pend_q & ~w1c_s) | term_s;
        irq_d  = |(pend_q & irq_en_s);
    end

    // Readback mux
    always_comb begin
        counter_out = '0;
        if (counter_ch < SEL_CTRL) begin
            counter_out = count_s[counter_ch];
        end else if (counter_ch == SEL_CTRL) begin
            counter_out = WIDTH'(ctrl_q);
        end else if (counter_ch == SEL_PEND) begin
            counter_out = WIDTH'(pend_q);
        end else begin
            counter_out = '0;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_bank_n.sv
// Scoreboard bench for timer_bank_n (NCH=3, WIDTH=32).
module tb_timer_bank_n;

    localparam int NCH   = 3;
    localparam int WIDTH = 32;
    localparam int SEL_W = 3;

    logic             clk;
    logic             rstn;
    logic [NCH-1:0]   tick;
    logic             counter_we;
    logic [SEL_W-1:0] counter_ch;
    logic [WIDTH-1:0] counter_val;
    logic [WIDTH-1:0] counter_out;
    logic [NCH-1:0]   ch_out;
    logic             irq;

    typedef struct {
        string            tag;
        int               kind;   // 0 register readback, 1 ch_out, 2 irq
        logic [SEL_W-1:0] sel;
        logic [31:0]      exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    timer_bank_n #(.NCH(NCH), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .tick        (tick),
        .counter_we  (counter_we),
        .counter_ch  (counter_ch),
        .counter_val (counter_val),
        .counter_out (counter_out),
        .ch_out      (ch_out),
        .irq         (irq)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_ctrl(input logic [1:0] m0, input logic [1:0] m1,
                                            input logic [1:0] m2, input logic [2:0] en,
                                            input logic [2:0] ie);
        return {20'd0, ie, en, m2, m1, m0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ex_reg(input string tag, input int sel, input logic [31:0] v);
        sb.push_back('{tag, 0, SEL_W'(sel), v});
    endtask

    task automatic ex_ch(input string tag, input logic [2:0] v);
        sb.push_back('{tag, 1, 3'd0, {29'd0, v}});
    endtask

    task automatic ex_irq(input string tag, input logic v);
        sb.push_back('{tag, 2, 3'd0, {31'd0, v}});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0: begin
                    counter_ch = e.sel;
                    #1;
                    chk(e.tag, counter_out, e.exp);
                end
                1:       chk(e.tag, {29'd0, ch_out}, e.exp);
                default: chk(e.tag, {31'd0, irq}, e.exp);
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int sel, input logic [31:0] val);
        counter_ch  = SEL_W'(sel);
        counter_val = val;
        counter_we  = 1'b1;
        cyc();
        counter_we  = 1'b0;
    endtask

    task automatic pulses(input int ch, input int n);
        repeat (n) begin
            tick[ch] = 1'b1;
            cyc();
            tick[ch] = 1'b0;
            cyc();
        end
    endtask

    initial begin
        logic [2:0] v;
        int sq;
        rstn        = 1'b1;
        tick        = '0;
        counter_we  = 1'b0;
        counter_ch  = '0;
        counter_val = '0;
        #5 rstn = 1'b0;
        #10;
        for (int s = 0; s < 5; s++) ex_reg($sformatf("reset sel%0d", s), s, 32'd0);
        ex_ch("reset ch_out", 3'b000);
        ex_irq("reset irq", 1'b0);
        drain();
        repeat (2) cyc();
        rstn = 1'b1;
        cyc();

        // 1: periodic on channel 0
        wr(3, mk_ctrl(2'b01, 2'b00, 2'b00, 3'b001, 3'b001));
        wr(0, 32'd5);
        ex_reg("t1 load", 0, 32'd5);
        drain();
        for (int k = 1; k <= 4; k++) begin
            pulses(0, 1);
            ex_reg($sformatf("t1 count e%0d", k), 0, 32'(5 - k));
            drain();
        end
        tick[0] = 1'b1;
        cyc();
        ex_ch("t1 pulse", 3'b001);
        ex_reg("t1 reloaded", 0, 32'd5);
        ex_reg("t1 pend", 4, 32'd1);
        ex_irq("t1 irq early", 1'b0);
        drain();
        tick[0] = 1'b0;
        cyc();
        ex_ch("t1 pulse end", 3'b000);
        ex_irq("t1 irq", 1'b1);
        drain();

        // 2: one-shot on channel 1
        wr(3, mk_ctrl(2'b01, 2'b00, 2'b00, 3'b011, 3'b001));
        wr(1, 32'd3);
        for (int k = 1; k <= 5; k++) begin
            pulses(1, 1);
            ex_reg($sformatf("t2 count e%0d", k), 1, (k < 3) ? 32'(3 - k) : 32'd0);
            ex_ch($sformatf("t2 ch e%0d", k), (k >= 3) ? 3'b010 : 3'b000);
            drain();
        end
        wr(1, 32'd3);
        ex_ch("t2 rewrite ch", 3'b000);
        ex_reg("t2 rewrite count", 1, 32'd3);
        drain();
        pulses(1, 1);
        ex_reg("t2 rerun", 1, 32'd2);
        drain();
        pulses(1, 2);
        ex_reg("t2 done again", 1, 32'd0);
        ex_ch("t2 ch again", 3'b010);
        drain();

        // 3: square on channel 2
        wr(3, mk_ctrl(2'b01, 2'b00, 2'b10, 3'b111, 3'b001));
        wr(2, 32'd2);
        for (int k = 1; k <= 8; k++) begin
            pulses(2, 1);
            sq = (k / 2) % 2;
            v  = {sq[0], 2'b10};
            ex_reg($sformatf("t3 count e%0d", k), 2, (k % 2 == 1) ? 32'd1 : 32'd2);
            ex_ch($sformatf("t3 ch e%0d", k), v);
            drain();
        end
        ex_reg("t3 pend", 4, 32'd7);
        ex_reg("t3 ctrl", 3, mk_ctrl(2'b01, 2'b00, 2'b10, 3'b111, 3'b001));
        ex_reg("t3 sel5", 5, 32'd0);
        drain();

        // 4: reload write collides with a count edge
        pulses(0, 1);
        ex_reg("t4 pre", 0, 32'd4);
        drain();
        tick[0] = 1'b1;
        wr(0, 32'd7);
        ex_reg("t4 collision", 0, 32'd7);
        drain();
        tick[0] = 1'b0;
        cyc();
        pulses(0, 1);
        ex_reg("t4 after", 0, 32'd6);
        drain();

        // 5: W1C, then W1C colliding with a terminal event
        wr(4, 32'd1);
        ex_reg("t5 pend cleared", 4, 32'd6);
        ex_irq("t5 irq still", 1'b1);
        drain();
        cyc();
        ex_irq("t5 irq low", 1'b0);
        drain();
        pulses(0, 5);
        ex_reg("t5 count1", 0, 32'd1);
        drain();
        tick[0] = 1'b1;
        wr(4, 32'd1);
        ex_reg("t5 set wins", 4, 32'd7);
        ex_reg("t5 reload", 0, 32'd7);
        ex_ch("t5 ch", 3'b011);
        drain();
        tick[0] = 1'b0;
        cyc();
        ex_irq("t5 irq back", 1'b1);
        ex_ch("t5 ch end", 3'b010);
        drain();

        // 6: enable gating, then asynchronous reset mid-count
        pulses(0, 4);
        ex_reg("t6 count3", 0, 32'd3);
        drain();
        wr(3, mk_ctrl(2'b01, 2'b00, 2'b10, 3'b110, 3'b001));
        pulses(0, 4);
        ex_reg("t6 frozen", 0, 32'd3);
        ex_ch("t6 ch", 3'b010);
        drain();
        wr(3, mk_ctrl(2'b01, 2'b00, 2'b10, 3'b111, 3'b001));
        pulses(0, 1);
        ex_reg("t6 resume", 0, 32'd2);
        drain();
        @(posedge clk);
        #20;
        rstn = 1'b0;
        #1;
        ex_ch("t6 rst ch_out", 3'b000);
        ex_irq("t6 rst irq", 1'b0);
        for (int s = 0; s < 5; s++) ex_reg($sformatf("t6 rst sel%0d", s), s, 32'd0);
        drain();
        cyc();
        rstn = 1'b1;
        cyc();
        pulses(0, 1);
        ex_reg("t6 post idle", 0, 32'd0);
        ex_ch("t6 post ch", 3'b000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
